// File: rtl/video_hwindow.sv
`default_nettype none
// ============================================================================
//  Module      : video_hwindow
//  Description : Programmable pixel clock-enable divider plus a horizontal
//                blanking window for the CLK_VIDEO domain. It measures the
//                active line length and applies left/right crop values.
//                The crop values are shadowed at the VBlank rise, so a crop
//                change never tears a frame.
//  Revision    : 1.0  initial release
// ============================================================================
module video_hwindow #(
  parameter int          DIV_W    = 2,
  parameter int          CNT_W    = 11,
  parameter int unsigned MIN_LINE = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] ce_div,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic             crop_en,
  input  logic [CNT_W-1:0] crop_left,
  input  logic [CNT_W-1:0] crop_right,
  output logic             ce_pix,
  output logic             hblank_out,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] line_len,
  output logic             line_len_valid
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [DIV_W-1:0] r_div;
  logic             r_prev_hbl;
  logic             r_prev_vbl;
  logic             r_en_s;
  logic [CNT_W-1:0] r_cl_s;
  logic [CNT_W-1:0] r_cr_s;

  logic             w_hbl_rise;
  logic             w_vbl_rise;
  logic             w_len_ok;
  logic [CNT_W:0]   w_right_diff;
  logic [CNT_W-1:0] w_right_edge;
  logic             w_crop_blank;

  // The first blank pixel after active video closes a line. The first
  // VBlank pixel marks the frame boundary where the crop values are latched.
  assign w_hbl_rise = ~r_prev_hbl & hblank_in;
  assign w_vbl_rise = ~r_prev_vbl & vblank_in;

  // The measured length is compared at 32 bits, so MIN_LINE may exceed the
  // counter range without wrapping.
  assign w_len_ok   = (32'(hcnt) >= MIN_LINE);

  // The right edge is computed one bit wider, then clamped to zero when the
  // right crop swallows the whole line. A zero edge blanks every pixel.
  assign w_right_diff = {1'b0, line_len} - {1'b0, r_cr_s};
  assign w_right_edge = (r_cr_s < line_len) ? w_right_diff[CNT_W-1:0] : '0;

  assign w_crop_blank = r_en_s & line_len_valid &
                        ((hcnt < r_cl_s) | (hcnt >= w_right_edge));

  // Free-running divider. A ratio lowered below the current count wraps at
  // once, so there is no long gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      ce_pix <= 1'b0;
    end else begin
      r_div  <= (r_div >= ce_div) ? '0 : r_div + 1'b1;
      ce_pix <= (r_div == '0);
    end
  end

  // Active-pixel counter. It clears in HBlank and saturates at full scale.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
    end else if (ce_pix) begin
      if (hblank_in)
        hcnt <= '0;
      else if (hcnt != c_cnt_max)
        hcnt <= hcnt + 1'b1;
    end
  end

  // Line-length capture at the HBlank rise. Short lines are treated as glitches
  // and discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_len       <= '0;
      line_len_valid <= 1'b0;
      r_prev_hbl     <= 1'b1;
    end else if (ce_pix) begin
      r_prev_hbl <= hblank_in;
      if (w_hbl_rise && w_len_ok) begin
        line_len       <= hcnt;
        line_len_valid <= 1'b1;
      end
    end
  end

  // Crop shadow registers. They load only at the VBlank rise and apply from
  // the next pixel onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_s     <= 1'b0;
      r_cl_s     <= '0;
      r_cr_s     <= '0;
      r_prev_vbl <= 1'b0;
    end else if (ce_pix) begin
      r_prev_vbl <= vblank_in;
      if (w_vbl_rise) begin
        r_en_s <= crop_en;
        r_cl_s <= crop_left;
        r_cr_s <= crop_right;
      end
    end
  end

  // Registered blanking output. It trails hblank_in by exactly one pixel.
  always_ff @(posedge clk) begin
    if (reset)
      hblank_out <= 1'b1;
    else if (ce_pix)
      hblank_out <= hblank_in | w_crop_blank;
  end

endmodule
`default_nettype wire
